// File: rtl/rx_resp_scheduler_if.sv
// ----------------------------------------------------------------------------
// rx_resp_scheduler_if
// Bundles the parser-side header fields, configuration, tx-arbiter handshake
// and response outputs of rx_resp_scheduler.
//   slave  : view taken by rx_resp_scheduler (fields/config/grant in, response out)
//   master : view taken by the parser / tx control side driving the scheduler
// Parameter CNT_W : width of sifs_cycles.
// ----------------------------------------------------------------------------
interface rx_resp_scheduler_if #(
  parameter int unsigned CNT_W = 16
);
  // configuration
  logic             resp_en;
  logic [47:0]      self_mac_addr;
  logic [CNT_W-1:0] sifs_cycles;
  // parsed header fields
  logic [31:0]      FC_DI;
  logic             FC_DI_valid;
  logic [47:0]      rx_addr;
  logic             rx_addr_valid;
  logic [47:0]      tx_addr;
  logic             tx_addr_valid;
  logic [1:0]       qos_ack_policy;
  logic             qos_ack_policy_valid;
  logic             blk_ack_req_ctrl_valid;
  logic [15:0]      blk_ack_req_ctrl;
  logic [15:0]      blk_ack_req_ssc;
  logic             blk_ack_req_ssc_valid;
  logic             fcs_valid;
  logic             fcs_ok;
  // tx arbiter handshake and response descriptor
  logic             resp_grant;
  logic             resp_req;
  logic [1:0]       resp_type;
  logic [47:0]      resp_ra;
  logic [3:0]       resp_tid;
  logic [15:0]      resp_ssc;
  logic [15:0]      resp_cnt;
  logic [15:0]      drop_cnt;

  modport slave (
    input  resp_en, self_mac_addr, sifs_cycles,
           FC_DI, FC_DI_valid, rx_addr, rx_addr_valid, tx_addr, tx_addr_valid,
           qos_ack_policy, qos_ack_policy_valid,
           blk_ack_req_ctrl_valid, blk_ack_req_ctrl,
           blk_ack_req_ssc, blk_ack_req_ssc_valid,
           fcs_valid, fcs_ok, resp_grant,
    output resp_req, resp_type, resp_ra, resp_tid, resp_ssc, resp_cnt, drop_cnt
  );

  modport master (
    output resp_en, self_mac_addr, sifs_cycles,
           FC_DI, FC_DI_valid, rx_addr, rx_addr_valid, tx_addr, tx_addr_valid,
           qos_ack_policy, qos_ack_policy_valid,
           blk_ack_req_ctrl_valid, blk_ack_req_ctrl,
           blk_ack_req_ssc, blk_ack_req_ssc_valid,
           fcs_valid, fcs_ok, resp_grant,
    input  resp_req, resp_type, resp_ra, resp_tid, resp_ssc, resp_cnt, drop_cnt
  );
endinterface

// File: rtl/rx_resp_scheduler.sv
// ----------------------------------------------------------------------------
// rx_resp_scheduler
// Sequences the ACK / BlockAck (optionally CTS) response after the rx field
// parser: collects header fields, evaluates the FCS result and response
// rules, waits SIFS, then holds resp_req until granted or timed out.
//
// Ports:
//   clk  : clock
//   rst  : synchronous reset, active-high
//   bus  : rx_resp_scheduler_if.slave (fields, config, grant in; response out)
// Parameters:
//   CNT_W         : SIFS counter / sifs_cycles width
//   GRANT_TIMEOUT : cycles resp_req is held without grant before dropping
// Configuration macro:
//   RX_RESP_CTS_EN : when defined, RTS (control subtype 1011) to self yields
//                    a CTS (resp_type 10); otherwise RTS gets no response.
// ----------------------------------------------------------------------------
module rx_resp_scheduler #(
  parameter int unsigned CNT_W         = 16,
  parameter int unsigned GRANT_TIMEOUT = 256
) (
  input logic              clk,
  input logic              rst,
  rx_resp_scheduler_if.slave bus
);

  localparam int unsigned WAIT_W = (GRANT_TIMEOUT > 1) ? $clog2(GRANT_TIMEOUT) : 1;
  localparam logic [WAIT_W-1:0] WAIT_LAST = WAIT_W'(GRANT_TIMEOUT - 1);

  typedef enum logic [1:0] {
    S_IDLE,
    S_COLLECT,
    S_SIFS,
    S_REQ
  } state_e;

  typedef enum logic [1:0] {
    RESP_ACK = 2'b00,
    RESP_BA  = 2'b01,
    RESP_CTS = 2'b10
  } resp_e;

  state_e            state_q;
  logic [7:0]        fc_q;        // only type/subtype drive decisions
  logic [47:0]       rx_addr_q;
  logic              rx_flag_q;
  logic [47:0]       tx_addr_q;
  logic              tx_flag_q;
  logic [1:0]        qos_pol_q;
  logic              qos_flag_q;
  logic [3:0]        bar_tid_q;
  logic              barc_flag_q;
  logic [15:0]       bar_ssc_q;
  logic              bars_flag_q;
  logic [CNT_W-1:0]  sifs_cnt_q;
  logic [WAIT_W-1:0] wait_q;

  logic              resp_req_q;
  logic [1:0]        resp_type_q;
  logic [47:0]       resp_ra_q;
  logic [3:0]        resp_tid_q;
  logic [15:0]       resp_ssc_q;
  logic [15:0]       resp_cnt_q;
  logic [15:0]       drop_cnt_q;

  logic              rule_ok;
  resp_e             type_d;
  logic              need_d;
  logic              frame_start;

  function automatic logic [15:0] sat_inc(input logic [15:0] v);
    return (v == 16'hFFFF) ? v : v + 16'd1;
  endfunction

  // Response rule evaluation on the collected header.
  always_comb begin
    rule_ok = 1'b0;
    type_d  = RESP_ACK;
    case (fc_q[3:2])
      2'b00: rule_ok = 1'b1;
      2'b10: rule_ok = !fc_q[7] || (qos_flag_q && (qos_pol_q == 2'b00));
      2'b01: begin
        if (fc_q[7:4] == 4'b1000) begin
          type_d  = RESP_BA;
          rule_ok = barc_flag_q && bars_flag_q;
        end
`ifdef RX_RESP_CTS_EN
        else if (fc_q[7:4] == 4'b1011) begin
          type_d  = RESP_CTS;
          rule_ok = 1'b1;
        end
`endif
      end
      default: rule_ok = 1'b0;
    endcase
    need_d = bus.resp_en && bus.fcs_ok && rx_flag_q && tx_flag_q &&
             (rx_addr_q == bus.self_mac_addr) && rule_ok;
  end

  // A new header restarts collection everywhere except while requesting.
  assign frame_start = bus.FC_DI_valid && (state_q != S_REQ);

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= S_IDLE;
      fc_q        <= '0;
      rx_addr_q   <= '0;
      rx_flag_q   <= 1'b0;
      tx_addr_q   <= '0;
      tx_flag_q   <= 1'b0;
      qos_pol_q   <= '0;
      qos_flag_q  <= 1'b0;
      bar_tid_q   <= '0;
      barc_flag_q <= 1'b0;
      bar_ssc_q   <= '0;
      bars_flag_q <= 1'b0;
      sifs_cnt_q  <= '0;
      wait_q      <= '0;
      resp_req_q  <= 1'b0;
      resp_type_q <= '0;
      resp_ra_q   <= '0;
      resp_tid_q  <= '0;
      resp_ssc_q  <= '0;
      resp_cnt_q  <= '0;
      drop_cnt_q  <= '0;
    end else begin
      case (state_q)
        S_IDLE: begin
          if (bus.FC_DI_valid) state_q <= S_COLLECT;
        end
        S_COLLECT: begin
          if (!bus.FC_DI_valid && bus.fcs_valid) begin
            if (need_d) begin
              state_q     <= S_SIFS;
              sifs_cnt_q  <= bus.sifs_cycles;
              resp_type_q <= type_d;
              resp_ra_q   <= tx_addr_q;
              resp_tid_q  <= (type_d == RESP_BA) ? bar_tid_q : '0;
              resp_ssc_q  <= (type_d == RESP_BA) ? bar_ssc_q : '0;
            end else begin
              state_q <= S_IDLE;
            end
          end
        end
        S_SIFS: begin
          if (bus.FC_DI_valid) begin
            drop_cnt_q <= sat_inc(drop_cnt_q);
            state_q    <= S_COLLECT;
          end else if (!bus.resp_en) begin
            drop_cnt_q <= sat_inc(drop_cnt_q);
            state_q    <= S_IDLE;
          end else if (sifs_cnt_q == '0) begin
            state_q    <= S_REQ;
            resp_req_q <= 1'b1;
            wait_q     <= '0;
          end else begin
            sifs_cnt_q <= sifs_cnt_q - CNT_W'(1);
          end
        end
        S_REQ: begin
          // Grant wins over a timeout expiring in the same cycle.
          if (bus.resp_grant) begin
            resp_req_q <= 1'b0;
            resp_cnt_q <= sat_inc(resp_cnt_q);
            state_q    <= S_IDLE;
          end else if (wait_q == WAIT_LAST) begin
            resp_req_q <= 1'b0;
            drop_cnt_q <= sat_inc(drop_cnt_q);
            state_q    <= S_IDLE;
          end else begin
            wait_q <= wait_q + WAIT_W'(1);
          end
        end
        default: state_q <= S_IDLE;
      endcase

      // Field capture shared by IDLE/COLLECT/SIFS; the header start clears
      // the flags of any previous frame.
      if (frame_start) begin
        fc_q        <= bus.FC_DI[7:0];
        rx_flag_q   <= 1'b0;
        tx_flag_q   <= 1'b0;
        qos_flag_q  <= 1'b0;
        barc_flag_q <= 1'b0;
        bars_flag_q <= 1'b0;
      end else if (state_q == S_COLLECT) begin
        if (bus.rx_addr_valid) begin
          rx_addr_q <= bus.rx_addr;
          rx_flag_q <= 1'b1;
        end
        if (bus.tx_addr_valid) begin
          tx_addr_q <= bus.tx_addr;
          tx_flag_q <= 1'b1;
        end
        if (bus.qos_ack_policy_valid) begin
          qos_pol_q  <= bus.qos_ack_policy;
          qos_flag_q <= 1'b1;
        end
        if (bus.blk_ack_req_ctrl_valid) begin
          bar_tid_q   <= bus.blk_ack_req_ctrl[15:12];
          barc_flag_q <= 1'b1;
        end
        if (bus.blk_ack_req_ssc_valid) begin
          bar_ssc_q   <= bus.blk_ack_req_ssc;
          bars_flag_q <= 1'b1;
        end
      end
    end
  end

  assign bus.resp_req  = resp_req_q;
  assign bus.resp_type = resp_type_q;
  assign bus.resp_ra   = resp_ra_q;
  assign bus.resp_tid  = resp_tid_q;
  assign bus.resp_ssc  = resp_ssc_q;
  assign bus.resp_cnt  = resp_cnt_q;
  assign bus.drop_cnt  = drop_cnt_q;

endmodule

// File: tb/tb_rx_resp_scheduler.sv
module tb_rx_resp_scheduler;

  localparam int          TO   = 256;
  localparam logic [47:0] SELF = 48'h02_11_22_33_44_55;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  rx_resp_scheduler_if #(.CNT_W(16)) bus ();

  rx_resp_scheduler #(.CNT_W(16), .GRANT_TIMEOUT(TO)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  int checks = 0;
  int errs   = 0;
  int resp_exp = 0;
  int drop_exp = 0;

  typedef struct {
    logic [31:0] fc;
    logic [47:0] ra;
    logic [47:0] ta;
    bit          has_ra;
    bit          has_ta;
    bit          has_qos;
    logic [1:0]  pol;
    bit          has_bc;
    logic [15:0] bc;
    bit          has_bs;
    logic [15:0] bs;
    bit          fcs_ok;
  } frame_t;

  typedef struct {
    logic [1:0]  rtype;
    logic [47:0] ra;
    logic [3:0]  tid;
    logic [15:0] ssc;
    int          rise;
    int          dur;
  } exp_t;

  exp_t sbq[$];

  task automatic chk(input string name, input logic [79:0] act, input logic [79:0] exp);
    checks++;
    if (act !== exp) begin
      errs++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Reference: which response a completed frame earns.
  function automatic bit model(input frame_t f, input logic en, output logic [1:0] t);
    bit rule;
    t    = 2'b00;
    rule = 1'b0;
    case (f.fc[3:2])
      2'b00: rule = 1'b1;
      2'b10: rule = (f.fc[7] == 1'b0) ? 1'b1 : (f.has_qos && f.pol == 2'b00);
      2'b01: begin
        if (f.fc[7:4] == 4'd8) begin
          t    = 2'b01;
          rule = f.has_bc && f.has_bs;
        end else if (f.fc[7:4] == 4'd11) begin
`ifdef RX_RESP_CTS_EN
          t    = 2'b10;
          rule = 1'b1;
`endif
        end
      end
      default: rule = 1'b0;
    endcase
    return rule && en && f.fcs_ok && f.has_ra && (f.ra == SELF) && f.has_ta;
  endfunction

  function automatic frame_t base(input logic [31:0] fc);
    frame_t f;
    f.fc = fc;          f.ra = SELF;          f.ta = 48'hA0_B1_C2_D3_E4_F5;
    f.has_ra = 1'b1;    f.has_ta = 1'b1;      f.has_qos = 1'b0; f.pol = 2'b00;
    f.has_bc = 1'b0;    f.bc = 16'h0;         f.has_bs = 1'b0;  f.bs = 16'h0;
    f.fcs_ok = 1'b1;
    return f;
  endfunction

  task automatic issue_frame(input frame_t f, output int fcs_cyc);
    tick();
    bus.FC_DI = f.fc; bus.FC_DI_valid = 1'b1;
    tick();
    bus.FC_DI_valid = 1'b0;
    if (f.has_ra) begin
      bus.rx_addr = f.ra; bus.rx_addr_valid = 1'b1; tick(); bus.rx_addr_valid = 1'b0;
    end
    if (f.has_ta) begin
      bus.tx_addr = f.ta; bus.tx_addr_valid = 1'b1; tick(); bus.tx_addr_valid = 1'b0;
    end
    if (f.has_qos) begin
      bus.qos_ack_policy = f.pol; bus.qos_ack_policy_valid = 1'b1; tick();
      bus.qos_ack_policy_valid = 1'b0;
    end
    if (f.has_bc) begin
      bus.blk_ack_req_ctrl = f.bc; bus.blk_ack_req_ctrl_valid = 1'b1; tick();
      bus.blk_ack_req_ctrl_valid = 1'b0;
    end
    if (f.has_bs) begin
      bus.blk_ack_req_ssc = f.bs; bus.blk_ack_req_ssc_valid = 1'b1; tick();
      bus.blk_ack_req_ssc_valid = 1'b0;
    end
    bus.fcs_ok = f.fcs_ok; bus.fcs_valid = 1'b1; fcs_cyc = cyc;
    tick();
    bus.fcs_valid = 1'b0;
  endtask

  // Pushes expectation, then plays the tx arbiter for one response.
  task automatic run_frame(input frame_t f, input int sifs, input int gdelay, input bit nogrant);
    bit         need;
    bit         seen;
    logic [1:0] t;
    exp_t       e;
    int         fc_cyc;
    bus.sifs_cycles = 16'(sifs);
    need = model(f, bus.resp_en, t);
    issue_frame(f, fc_cyc);
    if (need) begin
      e.rtype = t;
      e.ra    = f.ta;
      e.tid   = (t == 2'b01) ? f.bc[15:12] : 4'h0;
      e.ssc   = (t == 2'b01) ? f.bs : 16'h0;
      e.rise  = fc_cyc + 2 + sifs;
      e.dur   = nogrant ? TO : gdelay + 1;
      sbq.push_back(e);
      seen = 1'b0;
      for (int i = 0; i < sifs + 6; i++) begin
        @(negedge clk);
        if (bus.resp_req) begin
          seen = 1'b1;
          break;
        end
      end
      if (!seen) begin
        chk("req_missing", {79'h0, bus.resp_req}, 80'h1);
        if (sbq.size() > 0) void'(sbq.pop_front());
      end else begin
        if (!nogrant) begin
          repeat (gdelay) @(negedge clk);
          bus.resp_grant = 1'b1;
          @(negedge clk);
          bus.resp_grant = 1'b0;
          resp_exp++;
        end else begin
          drop_exp++;
        end
        for (int i = 0; i < TO + 10 && bus.resp_req; i++) @(negedge clk);
      end
    end else begin
      repeat (sifs + 4) @(posedge clk);
    end
    tick();
    tick();
    chk("resp_cnt", 80'(bus.resp_cnt), 80'(resp_exp));
    chk("drop_cnt", 80'(bus.drop_cnt), 80'(drop_exp));
  endtask

  // Monitor: pops an expectation on every resp_req rise.
  initial begin : monitor
    exp_t cur;
    bit   active;
    bit   prev;
    int   hi;
    active = 1'b0;
    prev   = 1'b0;
    hi     = 0;
    forever begin
      @(negedge clk);
      if (rst === 1'b1) begin
        active = 1'b0;
        prev   = 1'b0;
        sbq.delete();
      end else begin
        if (bus.resp_req && !prev) begin
          if (sbq.size() == 0) begin
            chk("unexpected_req", {79'h0, bus.resp_req}, 80'h0);
          end else begin
            cur    = sbq.pop_front();
            active = 1'b1;
            hi     = 1;
            chk("rise_cycle", 80'(cyc), 80'(cur.rise));
            chk("resp_type", 80'(bus.resp_type), 80'(cur.rtype));
            chk("resp_ra", 80'(bus.resp_ra), 80'(cur.ra));
            chk("resp_tid", 80'(bus.resp_tid), 80'(cur.tid));
            chk("resp_ssc", 80'(bus.resp_ssc), 80'(cur.ssc));
          end
        end else if (bus.resp_req && active) begin
          hi++;
          chk("resp_hold", 80'({bus.resp_type, bus.resp_tid, bus.resp_ssc, bus.resp_ra}),
              80'({cur.rtype, cur.tid, cur.ssc, cur.ra}));
        end
        if (!bus.resp_req && prev && active) begin
          chk("req_len", 80'(hi), 80'(cur.dur));
          active = 1'b0;
        end
        prev = bus.resp_req;
      end
    end
  end

  initial begin : watchdog
    #1_000_000;
    $display("FAIL watchdog: got no finish expected finish by 1ms");
    $fatal(1, "watchdog expired");
  end

  initial begin : stim
    frame_t     f;
    frame_t     f2;
    int         fcc;
    int         r;
    logic [63:0] rnd;
    rst = 1'b1;
    bus.resp_en = 1'b1;           bus.self_mac_addr = SELF;     bus.sifs_cycles = 16'd10;
    bus.FC_DI = '0;               bus.FC_DI_valid = 1'b0;
    bus.rx_addr = '0;             bus.rx_addr_valid = 1'b0;
    bus.tx_addr = '0;             bus.tx_addr_valid = 1'b0;
    bus.qos_ack_policy = '0;      bus.qos_ack_policy_valid = 1'b0;
    bus.blk_ack_req_ctrl = '0;    bus.blk_ack_req_ctrl_valid = 1'b0;
    bus.blk_ack_req_ssc = '0;     bus.blk_ack_req_ssc_valid = 1'b0;
    bus.fcs_valid = 1'b0;         bus.fcs_ok = 1'b0;            bus.resp_grant = 1'b0;
    repeat (3) tick();
    chk("rst_req", 80'(bus.resp_req), 80'h0);
    chk("rst_type", 80'(bus.resp_type), 80'h0);
    chk("rst_ra", 80'(bus.resp_ra), 80'h0);
    chk("rst_tid_ssc", 80'({bus.resp_tid, bus.resp_ssc}), 80'h0);
    chk("rst_cnts", 80'({bus.resp_cnt, bus.drop_cnt}), 80'h0);
    rst = 1'b0;
    tick();

    // Non-QoS data to self, grant three cycles after the rise.
    run_frame(base(32'h0000_0008), 10, 3, 1'b0);

    // No-response cases.
    f = base(32'h0000_0088); f.has_qos = 1'b1; f.pol = 2'b01;
    run_frame(f, 10, 0, 1'b0);
    f = base(32'h0000_0008); f.fcs_ok = 1'b0;
    run_frame(f, 10, 0, 1'b0);
    f = base(32'h0000_0008); f.ra = 48'h02_11_22_33_44_56;
    run_frame(f, 10, 0, 1'b0);
    f = base(32'h0000_0088);                  // QoS data without policy field
    run_frame(f, 4, 0, 1'b0);
    f = base(32'h0000_0088); f.has_qos = 1'b1; f.pol = 2'b00;
    run_frame(f, 0, 0, 1'b0);

    // BlockAckReq to self.
    f = base(32'h0000_0084); f.has_bc = 1'b1; f.bc = 16'h5004; f.has_bs = 1'b1; f.bs = 16'h0120;
    run_frame(f, 10, 1, 1'b0);
    f.has_bs = 1'b0;                          // missing SSC field
    run_frame(f, 2, 0, 1'b0);

    // Grant never arrives, then grant exactly at expiry.
    run_frame(base(32'h0000_0000), 3, 0, 1'b1);
    run_frame(base(32'h0000_0008), 1, TO - 1, 1'b0);

    // New header during SIFS aborts the first frame.
    bus.sifs_cycles = 16'd10;
    issue_frame(base(32'h0000_0008), fcc);
    repeat (3) tick();
    drop_exp++;
    f2 = base(32'h0000_0000); f2.ta = 48'h12_34_56_78_9A_BC;
    run_frame(f2, 10, 2, 1'b0);

    // resp_en dropped during SIFS aborts to IDLE.
    bus.sifs_cycles = 16'd8;
    issue_frame(base(32'h0000_0008), fcc);
    tick();
    tick();
    bus.resp_en = 1'b0;
    tick();
    bus.resp_en = 1'b1;
    drop_exp++;
    repeat (14) tick();
    chk("en_abort_resp_cnt", 80'(bus.resp_cnt), 80'(resp_exp));
    chk("en_abort_drop_cnt", 80'(bus.drop_cnt), 80'(drop_exp));

    // RTS to self.
    run_frame(base(32'h0000_00B4), 5, 0, 1'b0);

    // Reset while requesting.
    bus.sifs_cycles = 16'd2;
    f = base(32'h0000_0008);
    issue_frame(f, fcc);
    begin
      exp_t e;
      bit   seen;
      e.rtype = 2'b00; e.ra = f.ta; e.tid = 4'h0; e.ssc = 16'h0;
      e.rise = fcc + 4; e.dur = TO;
      sbq.push_back(e);
      seen = 1'b0;
      for (int i = 0; i < 10; i++) begin
        @(negedge clk);
        if (bus.resp_req) begin
          seen = 1'b1;
          break;
        end
      end
      chk("req_before_rst", 80'(bus.resp_req), 80'h1);
    end
    @(posedge clk);
    #1;
    rst = 1'b1;
    @(posedge clk);
    #1;
    rst = 1'b0;
    resp_exp = 0;
    drop_exp = 0;
    chk("rst_req_low", 80'(bus.resp_req), 80'h0);
    chk("rst_cnt_clear", 80'({bus.resp_cnt, bus.drop_cnt}), 80'h0);
    tick();

    // Randomized frames.
    for (int n = 0; n < 40; n++) begin
      f = base($urandom);
      r = $urandom_range(0, 5);
      case (r)
        0:       f.fc[3:2] = 2'b00;
        1, 2:    f.fc[3:2] = 2'b10;
        3:       begin f.fc[3:2] = 2'b01; f.fc[7:4] = 4'd8;  end
        4:       begin f.fc[3:2] = 2'b01; f.fc[7:4] = 4'd11; end
        default: f.fc[3:2] = 2'($urandom_range(1, 3) | 1);
      endcase
      f.has_ra  = ($urandom_range(0, 9) != 0);
      rnd       = {$urandom, $urandom};
      f.ra      = ($urandom_range(0, 3) != 0) ? SELF : rnd[47:0];
      rnd       = {$urandom, $urandom};
      f.ta      = rnd[47:0];
      f.has_ta  = ($urandom_range(0, 9) != 0);
      f.has_qos = ($urandom_range(0, 3) != 0);
      f.pol     = 2'($urandom_range(0, 3));
      f.has_bc  = ($urandom_range(0, 5) != 0);
      f.bc      = 16'($urandom);
      f.has_bs  = ($urandom_range(0, 5) != 0);
      f.bs      = 16'($urandom);
      f.fcs_ok  = ($urandom_range(0, 7) != 0);
      bus.resp_en = ($urandom_range(0, 9) != 0);
      run_frame(f, $urandom_range(0, 12), $urandom_range(0, 6), ($urandom_range(0, 11) == 0));
    end
    bus.resp_en = 1'b1;
    repeat (4) tick();

    $display("Result: errors=%0d of %0d checks", errs, checks);
    $finish;
  end

endmodule
